// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit between the execute stage and
// the data memory. Sub-word stores are done as read-modify-write. Sub-word
// loads are lane-extracted, then sign- or zero-extended. All outputs are
// registered.
module dmem_lsu #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_rdata,
  output logic                  mem_enable,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;

  // Latched request fields (word-store data goes straight to r_mem_data_in)
  logic                  r_write;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [1:0]            r_addr_lo;
  logic [15:0]           r_wdata;

  // Registered outputs
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_error;
  logic [31:0]           r_resp_rdata;
  logic                  r_mem_enable;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_data_in;

  logic                  w_req_err;
  logic                  w_word_store;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [31:0]           w_merge;

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_error       = r_resp_error;
  assign resp_rdata       = r_resp_rdata;
  assign mem_enable       = r_mem_enable;
  assign mem_read_enable  = r_mem_read;
  assign mem_write_enable = r_mem_write;
  assign mem_address      = r_mem_address;
  assign mem_data_in      = r_mem_data_in;

  assign w_word_store = req_write && (req_size == 2'b10);

  // Size legality and natural alignment of the incoming request
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  // Lane extraction with extension for loads, lane merge for sub-word stores
  always_comb begin
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0:    w_byte = mem_data_out[7:0];
      2'd1:    w_byte = mem_data_out[15:8];
      2'd2:    w_byte = mem_data_out[23:16];
      default: w_byte = mem_data_out[31:24];
    endcase
    w_half = r_addr_lo[1] ? mem_data_out[31:16] : mem_data_out[15:0];

    w_load = mem_data_out;
    case (r_size)
      2'b00:   w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_load = mem_data_out;
    endcase

    w_merge = mem_data_out;
    if (r_size == 2'b00) begin
      case (r_addr_lo)
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr_lo[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end

  // Request/response FSM; strobes are set on entry to RD/WR so they are registered.
  // RD runs READ_LATENCY strobed cycles and then one unstrobed cycle in which
  // the read data is valid and captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= '0;
      r_addr_lo     <= '0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_error  <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write       <= req_write;
            r_unsigned    <= req_unsigned;
            r_size        <= req_size;
            r_addr_lo     <= req_addr[1:0];
            r_wdata       <= req_wdata[15:0];
            r_req_ready   <= 1'b0;
            r_mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= S_RESP;
            end else if (w_word_store) begin
              r_mem_data_in <= req_wdata;
              r_mem_enable  <= 1'b1;
              r_mem_write   <= 1'b1;
              r_state       <= S_WR;
            end else begin
              r_mem_enable <= 1'b1;
              r_mem_read   <= 1'b1;
              r_cnt        <= CW'(READ_LATENCY);
              r_state      <= S_RD;
            end
          end
        end

        S_RD: begin
          if (r_cnt == '0) begin
            if (r_write) begin
              r_mem_data_in <= w_merge;
              r_mem_enable  <= 1'b1;
              r_mem_write   <= 1'b1;
              r_state       <= S_WR;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_rdata <= w_load;
              r_state      <= S_RESP;
            end
          end else begin
            if (r_cnt == CW'(1)) begin
              r_mem_enable <= 1'b0;
              r_mem_read   <= 1'b0;
            end
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_WR: begin
          r_mem_enable <= 1'b0;
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_error <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= S_RESP;
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_resp_rdata <= '0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
